// File: rtl/mem_view_pkg.sv
// rtl/mem_view_pkg.sv - view mode encoding, screen geometry and derived fetch constants
package mem_view_pkg;

   typedef enum logic [1:0] {
      MODE_BOTH  = 2'd0,
      MODE_BIN   = 2'd1,
      MODE_HEX   = 2'd2,
      MODE_BLANK = 2'd3
   } view_mode_t;

   localparam int SCREEN_W   = 640;
   localparam int SCREEN_H   = 480;
   localparam int BIN_PANE_W = 512;

   // screen pixels covered by one RAM word in the binary pane
   function automatic int calc_ppw(input int ram_width, input int bits_x);
      return 1 << ($clog2(ram_width) + bits_x);
   endfunction

   function automatic int calc_wpl(input int ppw);
      return BIN_PANE_W / ppw;
   endfunction

   function automatic int calc_hpw(input int ram_width, input int px_per_digit);
      return ram_width / 4 * px_per_digit;
   endfunction

   function automatic int calc_hex_digits(input int bits_x);
      return (bits_x <= 4) ? 8 : 4;
   endfunction

   function automatic int calc_wphl(input int ram_width, input int bits_x);
      return 4 * calc_hex_digits(bits_x) / ram_width;
   endfunction

endpackage

// File: rtl/mem_view_pipe.sv
// rtl/mem_view_pipe.sv - fixed-depth register delay line with async reset
module mem_view_pipe #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mem_view_fetch.sv
// rtl/mem_view_fetch.sv - pixel -> RAM word -> binary bit / hex nibble fetch pipeline
// MEM_VIEW_CURSOR_EN adds cursor_addr/out_cursor (blinking word highlight).
module mem_view_fetch
   import mem_view_pkg::*;
#(
   parameter int RAM_WIDTH               = 16,
   parameter int ADDR_WIDTH              = 8,
   parameter int BITS_PER_MEMORY_PIXEL_X = 4,
   parameter int BITS_PER_MEMORY_PIXEL_Y = 5,
   parameter int HEX_START_X             = 512,
   parameter int PIXELS_PER_HEX_DIGIT    = 16,
   parameter int READ_LATENCY            = 1
) (
   input  logic                  CLK_50,
   input  logic                  reset,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [1:0]            cfg_mode,
   output logic [ADDR_WIDTH-1:0] addr_screen,
   input  logic [RAM_WIDTH-1:0]  rdata_screen,
`ifdef MEM_VIEW_CURSOR_EN
   input  logic [ADDR_WIDTH-1:0] cursor_addr,
   output logic                  out_cursor,
`endif
   output logic                  out_valid,
   output logic [9:0]            out_x,
   output logic [9:0]            out_y,
   output logic                  out_in_hex,
   output logic                  out_bit,
   output logic [3:0]            out_nibble,
   output logic [7:0]            frame_count
);

   localparam int PPW       = calc_ppw(RAM_WIDTH, BITS_PER_MEMORY_PIXEL_X);
   localparam int WPL       = calc_wpl(PPW);
   localparam int HPW       = calc_hpw(RAM_WIDTH, PIXELS_PER_HEX_DIGIT);
   localparam int WPHL      = calc_wphl(RAM_WIDTH, BITS_PER_MEMORY_PIXEL_X);
   localparam int HEX_END_X = HEX_START_X
                              + calc_hex_digits(BITS_PER_MEMORY_PIXEL_X) * PIXELS_PER_HEX_DIGIT;
`ifdef MEM_VIEW_CURSOR_EN
   localparam int PIPE_W = 22 + ADDR_WIDTH;
`else
   localparam int PIPE_W = 22;
`endif

   logic [9:0]            s0_x, s0_y;
   logic                  s0_live;
   logic [ADDR_WIDTH-1:0] act_base, pend_base, eff_base;
   view_mode_t            act_mode, pend_mode, eff_mode;
   logic                  pend_valid, boundary;
   int                    s0_xi, s0_yi, row, offset;
   logic                  in_bin, in_hex, a_valid_next, a_hex_next;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [9:0]            a_x, a_y, d_x, d_y;
   logic                  a_valid, a_hex, d_valid, d_hex;
   logic [PIPE_W-1:0]     pipe_in, pipe_out;
   int                    d_xi, bit_idx, digit;
   logic                  bit_sel;
   logic [3:0]            nib_sel;

   // s0_live keeps the reset-cleared (0,0) in S0 from looking like a frame start
   assign boundary = s0_live && (s0_x == 10'd0) && (s0_y == 10'd0);
   assign eff_base = (boundary && pend_valid) ? pend_base : act_base;
   assign eff_mode = (boundary && pend_valid) ? pend_mode : act_mode;

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         s0_x        <= '0;
         s0_y        <= '0;
         s0_live     <= 1'b0;
         act_base    <= '0;
         act_mode    <= MODE_BOTH;
         pend_base   <= '0;
         pend_mode   <= MODE_BOTH;
         pend_valid  <= 1'b0;
         cfg_ready   <= 1'b1;
         frame_count <= '0;
      end else begin
         s0_x    <= pixel_x;
         s0_y    <= pixel_y;
         s0_live <= 1'b1;
         if (boundary) begin
            frame_count <= frame_count + 8'd1;
            if (pend_valid) begin
               act_base <= pend_base;
               act_mode <= pend_mode;
            end
         end
         if (cfg_valid && cfg_ready) begin
            pend_base  <= cfg_base;
            pend_mode  <= view_mode_t'(cfg_mode);
            pend_valid <= 1'b1;
            cfg_ready  <= 1'b0;
         end else if (boundary && pend_valid) begin
            pend_valid <= 1'b0;
            cfg_ready  <= 1'b1;
         end
      end
   end

   always_comb begin
      s0_xi  = int'(s0_x);
      s0_yi  = int'(s0_y);
      row    = s0_yi >> BITS_PER_MEMORY_PIXEL_Y;
      in_bin = s0_xi < HEX_START_X;
      in_hex = (s0_xi >= HEX_START_X) && (s0_xi < HEX_END_X);
      if (in_bin) offset = row * WPL + s0_xi / PPW;
      else        offset = row * WPHL + (s0_xi - HEX_START_X) / HPW;
      addr_next    = ADDR_WIDTH'(offset) + eff_base;
      a_hex_next   = s0_live && in_hex;
      a_valid_next = s0_live && (s0_xi < SCREEN_W) && (s0_yi < SCREEN_H) &&
                     ((in_bin && (eff_mode == MODE_BOTH || eff_mode == MODE_BIN)) ||
                      (in_hex && (eff_mode == MODE_BOTH || eff_mode == MODE_HEX)));
   end

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         addr_screen <= '0;
         a_x         <= '0;
         a_y         <= '0;
         a_valid     <= 1'b0;
         a_hex       <= 1'b0;
      end else begin
         addr_screen <= addr_next;
         a_x         <= s0_x;
         a_y         <= s0_y;
         a_valid     <= a_valid_next;
         a_hex       <= a_hex_next;
      end
   end

`ifdef MEM_VIEW_CURSOR_EN
   logic [ADDR_WIDTH-1:0] d_addr;
   assign pipe_in = {addr_screen, a_x, a_y, a_valid, a_hex};
   assign {d_addr, d_x, d_y, d_valid, d_hex} = pipe_out;
`else
   assign pipe_in = {a_x, a_y, a_valid, a_hex};
   assign {d_x, d_y, d_valid, d_hex} = pipe_out;
`endif

   mem_view_pipe #(
      .WIDTH (PIPE_W),
      .DEPTH (READ_LATENCY)
   ) u_align (
      .clk  (CLK_50),
      .rst  (reset),
      .din  (pipe_in),
      .dout (pipe_out)
   );

   // MSB of the word is the leftmost bit / most significant nibble on screen
   always_comb begin
      d_xi    = int'(d_x);
      bit_idx = 0;
      digit   = 0;
      if (d_hex) digit = ((d_xi - HEX_START_X) % HPW) / PIXELS_PER_HEX_DIGIT;
      else       bit_idx = (d_xi % PPW) >> BITS_PER_MEMORY_PIXEL_X;
      bit_sel = 1'(rdata_screen >> (RAM_WIDTH - 1 - bit_idx));
      nib_sel = 4'(rdata_screen >> (RAM_WIDTH - 4 - 4 * digit));
   end

   always_ff @(posedge CLK_50 or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
         out_in_hex <= 1'b0;
         out_bit    <= 1'b0;
         out_nibble <= '0;
`ifdef MEM_VIEW_CURSOR_EN
         out_cursor <= 1'b0;
`endif
      end else begin
         out_valid  <= d_valid;
         out_x      <= d_x;
         out_y      <= d_y;
         out_in_hex <= d_hex;
         out_bit    <= d_valid && !d_hex && bit_sel;
         out_nibble <= (d_valid && d_hex) ? nib_sel : 4'd0;
`ifdef MEM_VIEW_CURSOR_EN
         out_cursor <= d_valid && (d_addr == cursor_addr) && frame_count[5];
`endif
      end
   end

endmodule

// File: tb/tb_mem_view_fetch.sv
// tb/tb_mem_view_fetch.sv - randomized bench for mem_view_fetch (latency 1 and 3) against a frame/config model
module tb_mem_view_fetch;

   localparam int RAMW    = 16;
   localparam int PPW     = 1 << (4 + 4);
   localparam int WPL     = 512 / PPW;
   localparam int HPW     = RAMW / 4 * 16;
   localparam int HEXD    = 8;
   localparam int WPHL    = 4 * HEXD / RAMW;
   localparam int HEX_END = 512 + HEXD * 16;
   localparam int MAXC    = 2100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   logic [9:0]  px, py;
   logic        cfg_valid;
   logic [7:0]  cfg_base;
   logic [1:0]  cfg_mode;
   logic        rdy1, rdy3;
   logic [7:0]  addr1, addr3, f1, f3;
   logic [15:0] rd1;
   logic [15:0] rd3 [3];
   logic        v1, h1, b1, v3, h3, b3;
   logic [3:0]  n1, n3;
   logic [9:0]  x1, y1, x3, y3;
`ifdef MEM_VIEW_CURSOR_EN
   logic [7:0]  cursor_addr = 8'd3;
   logic        c1, c3;
`endif

   logic [15:0] mem [256];
   always @(posedge clk) begin
      rd1    <= mem[addr1];
      rd3[0] <= mem[addr3];
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end

   mem_view_fetch #(.READ_LATENCY(1)) dut1 (
      .CLK_50(clk), .reset(rst), .pixel_x(px), .pixel_y(py),
      .cfg_valid(cfg_valid), .cfg_ready(rdy1), .cfg_base(cfg_base), .cfg_mode(cfg_mode),
      .addr_screen(addr1), .rdata_screen(rd1),
`ifdef MEM_VIEW_CURSOR_EN
      .cursor_addr(cursor_addr), .out_cursor(c1),
`endif
      .out_valid(v1), .out_x(x1), .out_y(y1), .out_in_hex(h1), .out_bit(b1),
      .out_nibble(n1), .frame_count(f1)
   );

   mem_view_fetch #(.READ_LATENCY(3)) dut3 (
      .CLK_50(clk), .reset(rst), .pixel_x(px), .pixel_y(py),
      .cfg_valid(cfg_valid), .cfg_ready(rdy3), .cfg_base(cfg_base), .cfg_mode(cfg_mode),
      .addr_screen(addr3), .rdata_screen(rd3[2]),
`ifdef MEM_VIEW_CURSOR_EN
      .cursor_addr(cursor_addr), .out_cursor(c3),
`endif
      .out_valid(v3), .out_x(x3), .out_y(y3), .out_in_hex(h3), .out_bit(b3),
      .out_nibble(n3), .frame_count(f3)
   );

   typedef struct packed {
      logic       valid;
      logic       hex;
      logic       b;
      logic [3:0] nib;
      logic [9:0] x;
      logic [9:0] y;
      logic [7:0] addr;
   } pix_t;

   pix_t       exp1 [MAXC+8];
   pix_t       exp3 [MAXC+8];
   logic [7:0] exp_addr  [MAXC];
   logic [7:0] exp_frame [MAXC];
   logic       exp_rdy   [MAXC];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // expected pixel result from the screen geometry, with the config active for that pixel
   function automatic pix_t predict(input int x, input int y, input int base, input int mode);
      pix_t r;
      int   a, w;
      if (x < 512) a = (base + (y >> 5) * WPL + x / PPW) % 256;
      else         a = (base + (y >> 5) * WPHL + (x - 512) / HPW) % 256;
      w       = int'(mem[8'(a)]);
      r.hex   = (x >= 512) && (x < HEX_END);
      r.valid = (x < 640) && (y < 480) &&
                ((x < 512 && (mode == 0 || mode == 1)) || (r.hex && (mode == 0 || mode == 2)));
      r.b     = (r.valid && !r.hex) ? 1'((w >> (15 - (x % PPW) / 16)) & 1) : 1'b0;
      r.nib   = (r.valid && r.hex) ? 4'((w >> (4 * (3 - ((x - 512) % HPW) / 16))) & 15) : 4'd0;
      r.x     = 10'(x);
      r.y     = 10'(y);
      r.addr  = 8'(a);
      return r;
   endfunction

   task automatic compare(input int e);
      check("addr_l1", {56'd0, addr1}, {56'd0, exp_addr[e]});
      check("addr_l3", {56'd0, addr3}, {56'd0, exp_addr[e]});
      check("cfg_ready", {63'd0, rdy1}, {63'd0, exp_rdy[e]});
      check("frame_count", {56'd0, f1}, {56'd0, exp_frame[e]});
      check("frame_count_l3", {56'd0, f3}, {56'd0, exp_frame[e]});
      check("pix_l1", {37'd0, v1, h1, b1, n1, x1, y1},
            {37'd0, exp1[e].valid, exp1[e].hex, exp1[e].b, exp1[e].nib, exp1[e].x, exp1[e].y});
      check("pix_l3", {37'd0, v3, h3, b3, n3, x3, y3},
            {37'd0, exp3[e].valid, exp3[e].hex, exp3[e].b, exp3[e].nib, exp3[e].x, exp3[e].y});
`ifdef MEM_VIEW_CURSOR_EN
      if (e > 0)
         check("cursor_l1", {63'd0, c1},
               {63'd0, exp1[e].valid && exp1[e].addr == cursor_addr && exp_frame[e-1][5]});
`endif
   endtask

   task automatic reset_check(input string tag);
      check(tag, {21'd0, v1, h1, b1, n1, x1, y1, addr1, f1}, 64'd0);
      check(tag, {21'd0, v3, h3, b3, n3, x3, y3, addr3, f3}, 64'd0);
      check(tag, {62'd0, rdy1, rdy3}, 64'd3);
   endtask

   task automatic run_segment(input int ncyc, input bit directed);
      pix_t pp;
      int   x, y, r, prev_x, prev_y;
      int   m_base, m_mode, p_base, p_mode, m_frame;
      bit   p_valid, m_ready, ready_pre, offer;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      if (directed) begin
         mem[5] = 16'h2000;
         mem[3] = 16'hA5C3;
      end
      for (int i = 0; i < MAXC + 8; i++) begin
         exp1[i] = '0;
         exp3[i] = '0;
      end
      m_base = 0; m_mode = 0; p_base = 0; p_mode = 0; p_valid = 0;
      m_frame = 0; m_ready = 1; offer = 0; prev_x = 0; prev_y = 0;
      for (int n = 0; n <= ncyc; n++) begin
         @(negedge clk);
         if (n == 0) rst = 1'b0;
         if (n >= 1) compare(n - 1);
         if (directed) begin
            case (n)
               2: check("tp_addr_bin", {56'd0, addr1}, 64'd5);
               3: check("tp_addr_hex", {56'd0, addr1}, 64'd3);
               4: check("tp_bin_out", {61'd0, v1, h1, b1}, 64'b101);
               5: check("tp_hex_out", {58'd0, v1, h1, n1}, 64'b110101);
               6: begin
                  check("tp_lat3_bit", {62'd0, v3, b3}, 64'b11);
                  check("tp_x640", {63'd0, v1}, 64'd0);
               end
               default: ;
            endcase
         end
         if (directed && n == 0)      begin x = 300; y = 70; end
         else if (directed && n == 1) begin x = 600; y = 40; end
         else if (directed && n == 2) begin x = 640; y = 10; end
         else begin
            r = $urandom_range(0, 19);
            if (r == 0)     begin x = 0; y = 0; end
            else if (r < 5) begin x = $urandom_range(480, 700); y = $urandom_range(0, 90); end
            else            begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
         end
         px = 10'(x);
         py = 10'(y);
         if (!offer && $urandom_range(0, 7) == 0) begin
            offer    = 1;
            cfg_base = 8'($urandom);
            cfg_mode = 2'($urandom);
         end
         cfg_valid = offer;
         // what the coming clock edge does: frame start, address of previous pixel, config accept
         ready_pre = m_ready;
         if (n >= 1) begin
            if (prev_x == 0 && prev_y == 0) begin
               if (p_valid) begin
                  m_base  = p_base;
                  m_mode  = p_mode;
                  p_valid = 0;
               end
               m_frame = (m_frame + 1) % 256;
            end
            pp          = predict(prev_x, prev_y, m_base, m_mode);
            exp_addr[n] = pp.addr;
            exp1[n+2]   = pp;
            exp3[n+4]   = pp;
         end else begin
            exp_addr[n] = 8'd0;
         end
         if (ready_pre && cfg_valid) begin
            p_base  = int'(cfg_base);
            p_mode  = int'(cfg_mode);
            p_valid = 1;
            offer   = 0;
         end
         m_ready      = !p_valid;
         exp_rdy[n]   = m_ready;
         exp_frame[n] = 8'(m_frame);
         prev_x = x;
         prev_y = y;
      end
   endtask

   initial begin
      px = '0; py = '0; cfg_valid = 1'b0; cfg_base = '0; cfg_mode = '0;
      repeat (2) @(negedge clk);
      reset_check("reset_state");
      run_segment(1500, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      reset_check("reset_mid_line");
      run_segment(1500, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
